// File: rtl/alink_rx_lane.sv
`default_nettype none
// ============================================================================
//  Module   : alink_rx_lane
//  Purpose  : Single-lane A-link receiver. Decodes pulse-coded bits on the
//             RX_P/RX_N pair into 32-bit words, frames WORDS words per report,
//             flags aborts and hands words to rxc through a 1-deep
//             valid/ready output register.
//  Options  : RX_LANE_GLITCH_FILTER_EN - when defined, a falling edge needs
//             the synchronised line to read 1,0,0 over three samples, so
//             1-clk low glitches are ignored (one extra clk of latency).
//  Revision : 1.0 - initial release
// ============================================================================
module alink_rx_lane #(
  parameter int WORDS  = 8,
  parameter int TOUT   = 1024,
  parameter int TOUT_W = 16,
  parameter int GAP    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        enable,
  input  logic        rx_p,
  input  logic        rx_n,
  output logic        word_vld,
  output logic [31:0] word_dat,
  input  logic        word_rdy,
  output logic        frame_last,
  output logic        frame_err,
  output logic        ovf,
  output logic        busy
);

  localparam int                WC_W        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int                GAP_W       = $clog2(GAP + 1);
  localparam logic [TOUT_W-1:0] c_tout      = TOUT_W'(TOUT);
  localparam logic [GAP_W-1:0]  c_gap       = GAP_W'(GAP);
  localparam logic [WC_W-1:0]   c_last_word = WC_W'(WORDS - 1);
  localparam logic [4:0]        c_last_bit  = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Line synchronisers and falling-edge detection
  // --------------------------------------------------------------------------
  logic p_s1_q, p_s2_q, p_h1_q;
  logic n_s1_q, n_s2_q, n_h1_q;
  logic w_p_fall, w_n_fall;

  // Two-flop synchronisers plus one history flop per line; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1_q <= 1'b1;
      p_s2_q <= 1'b1;
      p_h1_q <= 1'b1;
      n_s1_q <= 1'b1;
      n_s2_q <= 1'b1;
      n_h1_q <= 1'b1;
    end else begin
      p_s1_q <= rx_p;
      p_s2_q <= p_s1_q;
      p_h1_q <= p_s2_q;
      n_s1_q <= rx_n;
      n_s2_q <= n_s1_q;
      n_h1_q <= n_s2_q;
    end
  end

`ifdef RX_LANE_GLITCH_FILTER_EN
  logic p_h2_q, n_h2_q;

  // Second history flop: an edge needs two consecutive low samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_h2_q <= 1'b1;
      n_h2_q <= 1'b1;
    end else begin
      p_h2_q <= p_h1_q;
      n_h2_q <= n_h1_q;
    end
  end

  assign w_p_fall = p_h2_q & ~p_h1_q & ~p_s2_q;
  assign w_n_fall = n_h2_q & ~n_h1_q & ~n_s2_q;
`else
  assign w_p_fall = p_h1_q & ~p_s2_q;
  assign w_n_fall = n_h1_q & ~n_s2_q;
`endif

  // A disabled lane sees no edges at all.
  logic w_p_edge, w_n_edge, w_bit, w_coll, w_lines_idle;
  assign w_p_edge     = w_p_fall & enable;
  assign w_n_edge     = w_n_fall & enable;
  assign w_bit        = w_p_edge ^ w_n_edge;
  assign w_coll       = w_p_edge & w_n_edge;
  assign w_lines_idle = p_s2_q & n_s2_q;

  // --------------------------------------------------------------------------
  // Receive state machine and output register
  // --------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [30:0]       shift_q, shift_d;
  logic              vld_q, vld_d;
  logic [31:0]       dat_q, dat_d;
  logic              last_q, last_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

  // Next-state, counter, shift-register and output-register decisions.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    tout_d     = tout_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    vld_d      = vld_q;
    dat_d      = dat_q;
    last_d     = last_q;
    ferr_d     = 1'b0;
    ovf_d      = 1'b0;

    // A consumed word frees the slot; a load below in the same cycle wins.
    if (vld_q && word_rdy) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_bit) begin
          state_d   = S_RECV;
          shift_d   = {shift_q[29:0], w_p_edge};
          bit_cnt_d = 5'd1;
          tout_d    = '0;
        end
      end

      S_RECV: begin
        if (!enable) begin
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tout_d     = '0;
        end else if (w_coll) begin
          state_d    = S_ERR;
          ferr_d     = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tout_d     = '0;
          gap_d      = '0;
        end else if (w_bit) begin
          tout_d  = '0;
          shift_d = {shift_q[29:0], w_p_edge};
          if (bit_cnt_q == c_last_bit) begin
            if (vld_q && !word_rdy) begin
              // Output still occupied: the new word has nowhere to go.
              state_d    = S_ERR;
              ovf_d      = 1'b1;
              ferr_d     = 1'b1;
              bit_cnt_d  = '0;
              word_cnt_d = '0;
              gap_d      = '0;
            end else begin
              vld_d     = 1'b1;
              dat_d     = {shift_q, w_p_edge};
              last_d    = (word_cnt_q == c_last_word);
              bit_cnt_d = '0;
              if (word_cnt_q == c_last_word) begin
                state_d    = S_IDLE;
                word_cnt_d = '0;
              end else begin
                word_cnt_d = word_cnt_q + WC_W'(1);
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (tout_q == c_tout) begin
          state_d    = S_IDLE;
          ferr_d     = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tout_d     = '0;
        end else begin
          tout_d = tout_q + TOUT_W'(1);
        end
      end

      S_ERR: begin
        if (!enable) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else if (gap_q == c_gap) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else if (w_lines_idle) begin
          gap_d = gap_q + GAP_W'(1);
        end else begin
          gap_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything decided above.
    if (flush) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      tout_d     = '0;
      gap_d      = '0;
      shift_d    = '0;
      vld_d      = 1'b0;
      last_d     = 1'b0;
      ferr_d     = 1'b0;
      ovf_d      = 1'b0;
    end
  end

  // State, counters, shift register and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tout_q     <= '0;
      gap_q      <= '0;
      shift_q    <= '0;
      vld_q      <= 1'b0;
      dat_q      <= '0;
      last_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tout_q     <= tout_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      last_q     <= last_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign word_vld   = vld_q;
  assign word_dat   = dat_q;
  assign frame_last = last_q;
  assign frame_err  = ferr_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
